// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory init/dump controller.
package dmem_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_SHIFT = 2;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2
  } state_e;

  // Word index to byte address.
  function automatic logic [DATA_W-1:0] word_to_byte(input logic [DATA_W-1:0] idx);
    return idx << ADDR_SHIFT;
  endfunction

endpackage

// File: rtl/dmem_word_counter.sv
// Word-index counter with clear, enable and terminal-count flag.
module dmem_word_counter #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [AW-1:0] o_idx,
  output logic          o_tc
);

  logic [AW-1:0] r_cnt;

  // Count up on enable; DEPTH is a power of two so the last increment wraps to 0.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + AW'(1);
    end
  end

  assign o_idx = r_cnt;
  assign o_tc  = (r_cnt == AW'(DEPTH - 1));

endmodule

// File: rtl/dmem_init_dump_ctrl.sv
// Owns the data-memory port: passes CPU traffic in RUN, streams an image in
// during LOAD and streams the contents out during DUMP.
module dmem_init_dump_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned AW            = 3,
  parameter bit          LOAD_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_writeData,
  input  logic              cpu_MemRead,
  input  logic              cpu_MemWrite,
  output logic [DATA_W-1:0] cpu_readData,
  output logic              cpu_stall,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              load_done,
  output logic              dump_valid,
  output logic [AW-1:0]     dump_addr,
  output logic [DATA_W-1:0] dump_data,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  input  logic [DATA_W-1:0] mem_readData
);

  state_e            r_state;
  logic              r_load_done;
  logic [AW-1:0]     w_idx;
  logic              w_tc;
  logic              w_clr;
  logic              w_en;
  logic [DATA_W-1:0] w_word_addr;

  // Index is held at 0 in RUN so each LOAD/DUMP starts from word 0.
  assign w_clr = (r_state == ST_RUN);
  assign w_en  = ((r_state == ST_LOAD) && ld_valid) ||
                 ((r_state == ST_DUMP) && dump_ready);
  assign w_word_addr = word_to_byte(DATA_W'(w_idx));

  dmem_word_counter #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (w_en),
    .o_idx (w_idx),
    .o_tc  (w_tc)
  );

  // Mode FSM and the one-cycle load_done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD_ON_RESET ? ST_LOAD : ST_RUN;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (start_load) begin
            r_state <= ST_LOAD;
          end else if (start_dump) begin
            r_state <= ST_DUMP;
          end
        end
        ST_LOAD: begin
          if (ld_valid && w_tc) begin
            r_state     <= ST_RUN;
            r_load_done <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (dump_ready && w_tc) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign load_done = r_load_done;

  // Memory-port and handshake decode from the current mode and index.
  always_comb begin
    mem_address   = '0;
    mem_writeData = '0;
    mem_MemRead   = 1'b0;
    mem_MemWrite  = 1'b0;
    cpu_readData  = '0;
    cpu_stall     = 1'b1;
    ld_ready      = 1'b0;
    dump_valid    = 1'b0;
    dump_addr     = '0;
    dump_data     = '0;
    case (r_state)
      ST_RUN: begin
        mem_address   = cpu_address;
        mem_writeData = cpu_writeData;
        mem_MemRead   = cpu_MemRead;
        mem_MemWrite  = cpu_MemWrite;
        cpu_readData  = mem_readData;
        cpu_stall     = 1'b0;
      end
      ST_LOAD: begin
        ld_ready      = 1'b1;
        mem_address   = w_word_addr;
        mem_writeData = ld_data;
        mem_MemWrite  = ld_valid;
      end
      ST_DUMP: begin
        mem_address = w_word_addr;
        mem_MemRead = 1'b1;
        dump_valid  = 1'b1;
        dump_addr   = w_idx;
        dump_data   = mem_readData;
      end
      default: ;
    endcase
    // Memory must never see a strobe while reset is asserted.
    if (rst) begin
      mem_MemRead  = 1'b0;
      mem_MemWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_init_dump_ctrl.sv
// Directed self-checking bench for dmem_init_dump_ctrl with a behavioural data memory.
module tb_dmem_init_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_address, cpu_writeData, cpu_readData;
  logic        cpu_MemRead, cpu_MemWrite, cpu_stall;
  logic        start_load, start_dump;
  logic        ld_valid, ld_ready, load_done;
  logic [31:0] ld_data;
  logic        dump_valid, dump_ready;
  logic [2:0]  dump_addr;
  logic [31:0] dump_data;
  logic [31:0] mem_address, mem_writeData, mem_readData;
  logic        mem_MemRead, mem_MemWrite;

  logic [31:0] tb_mem [8];
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write on posedge.
  assign mem_readData = tb_mem[mem_address[4:2]];
  always @(posedge clk) begin
    if (mem_MemWrite) tb_mem[mem_address[4:2]] <= mem_writeData;
  end

  dmem_init_dump_ctrl #(.DEPTH(8), .AW(3), .LOAD_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .cpu_address(cpu_address), .cpu_writeData(cpu_writeData),
    .cpu_MemRead(cpu_MemRead), .cpu_MemWrite(cpu_MemWrite),
    .cpu_readData(cpu_readData), .cpu_stall(cpu_stall),
    .start_load(start_load), .start_dump(start_dump),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .load_done(load_done),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_ready(dump_ready),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_readData(mem_readData)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream n words base+i from index 0; optional one-cycle valid gap before odd words.
  task automatic load_words(input logic [31:0] base, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && i[0]) begin
        ld_valid = 1'b0;
        #1;
        chk("ld_gap_nowrite", 32'(mem_MemWrite), 32'd0);
        chk("ld_gap_ready", 32'(ld_ready), 32'd1);
        step();
      end
      ld_valid = 1'b1;
      ld_data  = base + 32'(i);
      #1;
      chk("ld_we", 32'(mem_MemWrite), 32'd1);
      chk("ld_addr", mem_address, 32'(i) * 32'd4);
      chk("ld_wdata", mem_writeData, base + 32'(i));
      chk("ld_stall", 32'(cpu_stall), 32'd1);
      chk("ld_done_early", 32'(load_done), 32'd0);
      step();
    end
    ld_valid = 1'b0;
  endtask

  logic [31:0] exp_mem [8];

  initial begin
    rst = 1'b1;
    cpu_address = '0; cpu_writeData = '0; cpu_MemRead = 1'b0; cpu_MemWrite = 1'b0;
    start_load = 1'b0; start_dump = 1'b0;
    ld_valid = 1'b0; ld_data = '0; dump_ready = 1'b0;
    step();
    step();

    // Strobes blocked while reset is high, even with requests pending.
    ld_valid = 1'b1; cpu_MemWrite = 1'b1; cpu_MemRead = 1'b1;
    #1;
    chk("rst_we", 32'(mem_MemWrite), 32'd0);
    chk("rst_re", 32'(mem_MemRead), 32'd0);
    step();
    rst = 1'b0; ld_valid = 1'b0; cpu_MemWrite = 1'b0; cpu_MemRead = 1'b0;
    #1;
    chk("rst_state_load", 32'(ld_ready), 32'd1);
    chk("rst_stall", 32'(cpu_stall), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_rdata", cpu_readData, 32'd0);

    // 1: initial image with valid gaps.
    load_words(32'h10, 8, 1'b1);
    #1;
    chk("t1_done_pulse", 32'(load_done), 32'd1);
    chk("t1_stall_off", 32'(cpu_stall), 32'd0);
    chk("t1_ready_off", 32'(ld_ready), 32'd0);
    step();
    chk("t1_done_clear", 32'(load_done), 32'd0);
    for (int i = 0; i < 8; i++) chk("t1_mem", tb_mem[i], 32'h10 + 32'(i));

    // 2: CPU store then load through the pass-through.
    cpu_address = 32'h08; cpu_writeData = 32'hDEAD; cpu_MemWrite = 1'b1;
    #1;
    chk("t2_st_we", 32'(mem_MemWrite), 32'd1);
    chk("t2_st_addr", mem_address, 32'h08);
    chk("t2_st_stall", 32'(cpu_stall), 32'd0);
    step();
    cpu_MemWrite = 1'b0; cpu_MemRead = 1'b1;
    #1;
    chk("t2_ld_re", 32'(mem_MemRead), 32'd1);
    chk("t2_ld_data", cpu_readData, 32'hDEAD);
    chk("t2_ld_stall", 32'(cpu_stall), 32'd0);
    step();
    cpu_MemRead = 1'b0;

    // 3 + 6: dump with toggling ready while the CPU tries to store.
    for (int i = 0; i < 8; i++) exp_mem[i] = 32'h10 + 32'(i);
    exp_mem[2] = 32'hDEAD;
    start_dump = 1'b1;
    #1;
    step();
    start_dump = 1'b0;
    cpu_address = 32'h0; cpu_writeData = 32'hBAD; cpu_MemWrite = 1'b1;
    for (int k = 0; k < 8; k++) begin
      dump_ready = 1'b0;
      #1;
      chk("t3_valid", 32'(dump_valid), 32'd1);
      chk("t3_addr_hold", 32'(dump_addr), 32'(k));
      chk("t3_data_hold", dump_data, exp_mem[k]);
      chk("t6_we_blocked", 32'(mem_MemWrite), 32'd0);
      chk("t6_stall", 32'(cpu_stall), 32'd1);
      step();
      dump_ready = 1'b1;
      #1;
      chk("t3_addr", 32'(dump_addr), 32'(k));
      chk("t3_data", dump_data, exp_mem[k]);
      chk("t3_re", 32'(mem_MemRead), 32'd1);
      chk("t3_rdata_zero", cpu_readData, 32'd0);
      step();
    end
    dump_ready = 1'b0; cpu_MemWrite = 1'b0;
    #1;
    chk("t3_back_run_valid", 32'(dump_valid), 32'd0);
    chk("t3_back_run_stall", 32'(cpu_stall), 32'd0);
    chk("t6_mem0", tb_mem[0], 32'h10);
    chk("t6_mem2", tb_mem[2], 32'hDEAD);
    chk("t3_load_done_quiet", 32'(load_done), 32'd0);

    // 4: simultaneous starts pick LOAD; a dump request inside LOAD is dropped.
    start_load = 1'b1; start_dump = 1'b1;
    #1;
    step();
    start_load = 1'b0; start_dump = 1'b0;
    #1;
    chk("t4_in_load", 32'(ld_ready), 32'd1);
    chk("t4_no_dump", 32'(dump_valid), 32'd0);
    start_dump = 1'b1;
    #1;
    step();
    start_dump = 1'b0;
    #1;
    chk("t4_still_load", 32'(ld_ready), 32'd1);
    chk("t4_dump_ignored", 32'(dump_valid), 32'd0);
    chk("t4_no_read", 32'(mem_MemRead), 32'd0);

    // 5: abort after three words with a synchronous reset.
    load_words(32'h20, 3, 1'b0);
    rst = 1'b1; ld_valid = 1'b1; ld_data = 32'h99;
    #1;
    chk("t5_rst_we", 32'(mem_MemWrite), 32'd0);
    chk("t5_rst_done", 32'(load_done), 32'd0);
    step();
    rst = 1'b0; ld_valid = 1'b0;
    #1;
    chk("t5_reset_state", 32'(ld_ready), 32'd1);
    chk("t5_no_done", 32'(load_done), 32'd0);
    chk("t5_kept0", tb_mem[0], 32'h20);
    chk("t5_kept2", tb_mem[2], 32'h22);
    chk("t5_untouched3", tb_mem[3], 32'h13);
    load_words(32'h30, 8, 1'b0);
    #1;
    chk("t5_done_pulse", 32'(load_done), 32'd1);
    chk("t5_stall_off", 32'(cpu_stall), 32'd0);
    step();
    chk("t5_done_clear", 32'(load_done), 32'd0);
    chk("t5_mem7", tb_mem[7], 32'h37);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
